// File: rtl/hdlc_mon_pkg.sv
// hdlc_mon_pkg
// Shared definitions for the HDLC line monitor: error category encoding,
// the two 8-bit line patterns the monitor decodes, and the category count.
// The error category value doubles as the readout select (RdSel) encoding.

package hdlc_mon_pkg;

    // Error categories, one saturating counter per category per channel
    typedef enum logic [1:0] {
        ERR_MISS_FLAG  = 2'd0,
        ERR_SPUR_FLAG  = 2'd1,
        ERR_MISS_ABORT = 2'd2,
        ERR_IDLE       = 2'd3
    } err_cat_e;

    localparam logic [7:0] FLAG_PATTERN  = 8'h7E;
    localparam logic [7:0] ABORT_PATTERN = 8'h7F;
    localparam int         NUM_CAT       = 4;

    // True when the eight most recent line bits form the given pattern
    function automatic logic patternMatch(input logic [7:0] bits, input logic [7:0] pattern);
        return (bits == pattern);
    endfunction

endpackage

// File: rtl/hdlc_mon_chan.sv
// hdlc_mon_chan
// One monitored HDLC channel. It decodes flags and aborts from the raw serial
// line on its own and compares them against the DUT status strobes. Four
// independent saturating error counters and a sticky ErrIrq are kept.
//
// Ports
//   Clk          clock, all state on rising edge
//   Rst          asynchronous reset, active-low
//   En           monitor enable; shift register, idle counter and abort
//                delay line freeze while low, flag delay line and arming clear
//   Line         serial line bit, one bit per cycle
//   ValidFrame   DUT frame-in-progress
//   FlagDetect   DUT flag-detect strobe
//   AbortSignal  DUT abort indication
//   ClrCnt       clear this channel's counters and ErrIrq
//   Cnt          counters, indexed by err_cat_e
//   ErrIrq       sticky: at least one error logged since the last clear

module hdlc_mon_chan
    import hdlc_mon_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int FLAG_LAT  = 2,
    parameter int ABORT_LAT = 1,
    parameter int IDLE_LEN  = 8
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             En,
    input  logic                             Line,
    input  logic                             ValidFrame,
    input  logic                             FlagDetect,
    input  logic                             AbortSignal,
    input  logic                             ClrCnt,
    output logic [NUM_CAT-1:0][CNT_W-1:0]    Cnt,
    output logic                             ErrIrq
);

    localparam int ARM_W  = $clog2(FLAG_LAT + 1);
    localparam int IDLE_W = $clog2(IDLE_LEN + 1);

    logic [7:0]           sh;
    logic [7:0]           shNext;
    logic                 flagHit;
    logic                 abortHit;
    logic [FLAG_LAT-1:0]  flagDly;
    logic [ABORT_LAT-1:0] abortDly;
    logic                 expFlag;
    logic                 abortDue;
    logic [ARM_W-1:0]     armCnt;
    logic                 armed;
    logic [IDLE_W-1:0]    idleCnt;
    logic                 idleFull;
    logic [NUM_CAT-1:0]   errEv;

    // Pattern matching looks at the register contents including this cycle's
    // bit, so a hit is known in the same cycle the last pattern bit is on Line.
    // The delay lines then put the expectation exactly LAT cycles after it.
    assign shNext   = {sh[6:0], Line};
    assign flagHit  = En && patternMatch(shNext, FLAG_PATTERN);
    assign abortHit = En && ValidFrame && patternMatch(shNext, ABORT_PATTERN);
    assign expFlag  = flagDly[FLAG_LAT-1];
    assign abortDue = abortDly[ABORT_LAT-1];
    assign armed    = (armCnt == ARM_W'(FLAG_LAT));
    assign idleFull = (idleCnt == IDLE_W'(IDLE_LEN));

    // Line shift register; all-ones after reset so no pattern can match until
    // real bits have been shifted in
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sh <= 8'hFF;
        end else if (En) begin
            sh <= shNext;
        end
    end

    // Flag expectation pipeline and arming. Spurious-flag checking waits until
    // the pipeline holds FLAG_LAT cycles of valid history after enable.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            flagDly <= '0;
            armCnt  <= '0;
        end else if (!En) begin
            flagDly <= '0;
            armCnt  <= '0;
        end else begin
            flagDly <= (flagDly << 1) | FLAG_LAT'(flagHit);
            if (!armed) begin
                armCnt <= armCnt + ARM_W'(1);
            end
        end
    end

    // Abort expectation pipeline; only aborts seen inside a frame are tracked
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            abortDly <= '0;
        end else if (En) begin
            abortDly <= (abortDly << 1) | ABORT_LAT'(abortHit);
        end
    end

    // Idle run length: consecutive cycles outside a frame, saturating
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            idleCnt <= '0;
        end else if (En) begin
            if (ValidFrame) begin
                idleCnt <= '0;
            end else if (!idleFull) begin
                idleCnt <= idleCnt + IDLE_W'(1);
            end
        end
    end

    // Per-cycle error events. AbortSignal with no decoded abort is allowed,
    // so there is no spurious-abort category.
    always_comb begin
        errEv                 = '0;
        errEv[ERR_MISS_FLAG]  = En && expFlag && !FlagDetect;
        errEv[ERR_SPUR_FLAG]  = En && FlagDetect && !expFlag && armed;
        errEv[ERR_MISS_ABORT] = En && abortDue && !AbortSignal;
        errEv[ERR_IDLE]       = En && idleFull && !ValidFrame && !Line;
    end

    // Saturating counters. A clear wins over accumulation, but an event in
    // the clearing cycle is still recorded as a count of one.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CAT; c++) begin
                if (ClrCnt) begin
                    Cnt[c] <= CNT_W'(errEv[c]);
                end else if (errEv[c] && (Cnt[c] != {CNT_W{1'b1}})) begin
                    Cnt[c] <= Cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky interrupt follows whatever the counters hold after a clear
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ErrIrq <= 1'b0;
        end else if (ClrCnt) begin
            ErrIrq <= |errEv;
        end else if (|errEv) begin
            ErrIrq <= 1'b1;
        end
    end

endmodule

// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor
// Multi-channel HDLC line checker. Each channel independently decodes flags
// and aborts from its serial line and counts missed flags, spurious flags,
// missed aborts and idle-pattern violations. Counters are read through a
// registered channel/category mux.
//
// Optional feature macro: HDLC_MON_TIMESTAMP_EN adds a free-running 32-bit
// cycle counter, a per-channel first-error timestamp and the FirstErrTime port.
//
// Ports
//   Clk           clock, all state on rising edge
//   Rst           asynchronous reset, active-low
//   En            global monitor enable
//   Line          serial bit per channel
//   ValidFrame    DUT frame-in-progress per channel
//   FlagDetect    DUT flag-detect strobe per channel
//   AbortSignal   DUT abort indication per channel
//   ClrCnt        per-channel counter/ErrIrq clear
//   RdCh          readout channel select (out-of-range reads 0)
//   RdSel         readout category (err_cat_e encoding)
//   RdData        selected counter, registered
//   ErrIrq        sticky per-channel error flag
//   ErrAny        OR of ErrIrq, registered
//   FirstErrTime  (macro only) first-error cycle stamp for RdCh, registered

module hdlc_line_monitor
    import hdlc_mon_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_W     = 8,
    parameter  int FLAG_LAT  = 2,
    parameter  int ABORT_LAT = 1,
    parameter  int IDLE_LEN  = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [NUM_CH-1:0] Line,
    input  logic [NUM_CH-1:0] ValidFrame,
    input  logic [NUM_CH-1:0] FlagDetect,
    input  logic [NUM_CH-1:0] AbortSignal,
    input  logic [NUM_CH-1:0] ClrCnt,
    input  logic [CH_W-1:0]   RdCh,
    input  logic [1:0]        RdSel,
    output logic [CNT_W-1:0]  RdData,
    output logic [NUM_CH-1:0] ErrIrq,
    output logic              ErrAny
`ifdef HDLC_MON_TIMESTAMP_EN
    ,
    output logic [31:0]       FirstErrTime
`endif
);

    logic [NUM_CAT-1:0][CNT_W-1:0] cntAll [NUM_CH];
    logic [CNT_W-1:0]              rdMux;

    // One checker per monitored line
    for (genvar g = 0; g < NUM_CH; g++) begin : gChan
        hdlc_mon_chan #(
            .CNT_W     (CNT_W),
            .FLAG_LAT  (FLAG_LAT),
            .ABORT_LAT (ABORT_LAT),
            .IDLE_LEN  (IDLE_LEN)
        ) uChan (
            .Clk         (Clk),
            .Rst         (Rst),
            .En          (En),
            .Line        (Line[g]),
            .ValidFrame  (ValidFrame[g]),
            .FlagDetect  (FlagDetect[g]),
            .AbortSignal (AbortSignal[g]),
            .ClrCnt      (ClrCnt[g]),
            .Cnt         (cntAll[g]),
            .ErrIrq      (ErrIrq[g])
        );
    end

    // Channel select by comparison rather than indexing, so a select beyond
    // the last channel simply matches nothing and reads back zero
    always_comb begin
        rdMux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (RdCh == CH_W'(c)) begin
                rdMux = cntAll[c][RdSel];
            end
        end
    end

    // Registered readout and summary interrupt
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            RdData <= '0;
            ErrAny <= 1'b0;
        end else begin
            RdData <= rdMux;
            ErrAny <= |ErrIrq;
        end
    end

`ifdef HDLC_MON_TIMESTAMP_EN
    logic [31:0]       tsCnt;
    logic [31:0]       firstErr [NUM_CH];
    logic [NUM_CH-1:0] tsCaptured;
    logic [31:0]       tsMux;

    // Free-running cycle counter, wraps
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tsCnt <= '0;
        end else begin
            tsCnt <= tsCnt + 32'd1;
        end
    end

    // Stamp the first cycle each channel's ErrIrq is seen high; the captured
    // bit keeps later errors from overwriting it until the channel is cleared
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tsCaptured <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                firstErr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ClrCnt[c]) begin
                    firstErr[c]   <= '0;
                    tsCaptured[c] <= 1'b0;
                end else if (ErrIrq[c] && !tsCaptured[c]) begin
                    firstErr[c]   <= tsCnt;
                    tsCaptured[c] <= 1'b1;
                end
            end
        end
    end

    // Timestamp readout uses the same channel select as RdData
    always_comb begin
        tsMux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (RdCh == CH_W'(c)) begin
                tsMux = firstErr[c];
            end
        end
    end

    // Registered so it lines up with RdData
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            FirstErrTime <= '0;
        end else begin
            FirstErrTime <= tsMux;
        end
    end
`endif

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb_hdlc_line_monitor
// Directed bench for hdlc_line_monitor. A main instance (4 channels, 8-bit
// counters) runs a table of single-channel scenarios; a second instance
// (3 channels, 2-bit counters) shares the inputs for saturation and
// out-of-range readout. Channel 0 carries all stimulus, others stay quiet.

module tb_hdlc_line_monitor;
    import hdlc_mon_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       En;
    logic [3:0] Line;
    logic [3:0] ValidFrame;
    logic [3:0] FlagDetect;
    logic [3:0] AbortSignal;
    logic [3:0] ClrCnt;
    logic [1:0] RdCh;
    logic [1:0] RdSel;
    logic [7:0] RdData;
    logic [3:0] ErrIrq;
    logic       ErrAny;
    logic [1:0] RdDataS;
    logic [2:0] ErrIrqS;
    logic       ErrAnyS;
`ifdef HDLC_MON_TIMESTAMP_EN
    logic [31:0] FirstErrTime;
    logic [31:0] FirstErrTimeS;
`endif

    int nErrors = 0;
    int nChecks = 0;

    typedef struct {
        string       name;
        logic [15:0] line;
        logic [15:0] vf;
        logic [15:0] fd;
        logic [15:0] ab;
        int          n;
        logic [7:0]  expMiss;
        logic [7:0]  expSpur;
        logic [7:0]  expAbort;
        logic [7:0]  expIdle;
        logic        expIrq;
    } vec_t;

    vec_t vecs[$];

    hdlc_line_monitor #(
        .NUM_CH(4), .CNT_W(8), .FLAG_LAT(2), .ABORT_LAT(1), .IDLE_LEN(8)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .En          (En),
        .Line        (Line),
        .ValidFrame  (ValidFrame),
        .FlagDetect  (FlagDetect),
        .AbortSignal (AbortSignal),
        .ClrCnt      (ClrCnt),
        .RdCh        (RdCh),
        .RdSel       (RdSel),
        .RdData      (RdData),
        .ErrIrq      (ErrIrq),
        .ErrAny      (ErrAny)
`ifdef HDLC_MON_TIMESTAMP_EN
        ,
        .FirstErrTime(FirstErrTime)
`endif
    );

    hdlc_line_monitor #(
        .NUM_CH(3), .CNT_W(2), .FLAG_LAT(2), .ABORT_LAT(1), .IDLE_LEN(8)
    ) dutSmall (
        .Clk         (Clk),
        .Rst         (Rst),
        .En          (En),
        .Line        (Line[2:0]),
        .ValidFrame  (ValidFrame[2:0]),
        .FlagDetect  (FlagDetect[2:0]),
        .AbortSignal (AbortSignal[2:0]),
        .ClrCnt      (ClrCnt[2:0]),
        .RdCh        (RdCh),
        .RdSel       (RdSel),
        .RdData      (RdDataS),
        .ErrIrq      (ErrIrqS),
        .ErrAny      (ErrAnyS)
`ifdef HDLC_MON_TIMESTAMP_EN
        ,
        .FirstErrTime(FirstErrTimeS)
`endif
    );

    // Free-running clock
    always #5 Clk = ~Clk;

    // Build one table entry
    function automatic vec_t mkVec(input string nm, input logic [15:0] ln, input logic [15:0] vf,
                                   input logic [15:0] fd, input logic [15:0] ab, input int n,
                                   input logic [7:0] m, input logic [7:0] s, input logic [7:0] a,
                                   input logic [7:0] i, input logic irq);
        vec_t v;
        v.name = nm; v.line = ln; v.vf = vf; v.fd = fd; v.ab = ab; v.n = n;
        v.expMiss = m; v.expSpur = s; v.expAbort = a; v.expIdle = i; v.expIrq = irq;
        return v;
    endfunction

    // Compare one value and log a failure line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Quiet line on every channel: inside a frame, all ones, no strobes
    task automatic quietInputs();
        En          = 1'b1;
        Line        = 4'hF;
        ValidFrame  = 4'hF;
        FlagDetect  = 4'h0;
        AbortSignal = 4'h0;
        ClrCnt      = 4'h0;
    endtask

    // Reset, then enough quiet cycles for the flag checker to arm
    task automatic doReset();
        Rst = 1'b0;
        quietInputs();
        tick();
        tick();
        Rst = 1'b1;
        repeat (4) tick();
    endtask

    // Drive channel 0 for n cycles (bit i of each mask = cycle i), then leave
    // it outside a frame with the line idle-high
    task automatic applyStimulus(input logic [15:0] ln, input logic [15:0] vf, input logic [15:0] fd,
                                 input logic [15:0] ab, input logic [15:0] clr, input int n);
        for (int i = 0; i < n; i++) begin
            Line[0]        = ln[i];
            ValidFrame[0]  = vf[i];
            FlagDetect[0]  = fd[i];
            AbortSignal[0] = ab[i];
            ClrCnt[0]      = clr[i];
            tick();
        end
        Line[0]        = 1'b1;
        ValidFrame[0]  = 1'b0;
        FlagDetect[0]  = 1'b0;
        AbortSignal[0] = 1'b0;
        ClrCnt[0]      = 1'b0;
    endtask

    // Read all four channel-0 counters through the registered mux
    task automatic checkCounts(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] expv [4];
        expv[0] = e0; expv[1] = e1; expv[2] = e2; expv[3] = e3;
        RdCh = 2'd0;
        for (int s = 0; s < 4; s++) begin
            RdSel = 2'(s);
            tick();
            checkOutput($sformatf("%s.cat%0d", nm, s), 32'(RdData), 32'(expv[s]));
        end
    endtask

    initial begin
        RdCh  = 2'd0;
        RdSel = 2'd0;
        quietInputs();
        Rst = 1'b0;
        #3;
        checkOutput("reset.RdData", 32'(RdData), 32'd0);
        checkOutput("reset.ErrIrq", 32'(ErrIrq), 32'd0);
        checkOutput("reset.ErrAny", 32'(ErrAny), 32'd0);

        // name, line, vf, fd, ab, n, miss, spur, abort, idle, irq
        vecs.push_back(mkVec("flagOk",        16'h037E, 16'h03FF, 16'h0200, 16'h0000, 10, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("flagMissed",    16'h037E, 16'h03FF, 16'h0000, 16'h0000, 10, 1, 0, 0, 0, 1));
        vecs.push_back(mkVec("flagEarly",     16'h037E, 16'h03FF, 16'h0100, 16'h0000, 10, 1, 1, 0, 0, 1));
        vecs.push_back(mkVec("flagLate",      16'h077E, 16'h07FF, 16'h0400, 16'h0000, 11, 1, 1, 0, 0, 1));
        vecs.push_back(mkVec("spurOnly",      16'h03FF, 16'h03FF, 16'h0008, 16'h0000, 10, 0, 1, 0, 0, 1));
        vecs.push_back(mkVec("abortMissed",   16'h03FE, 16'h03FF, 16'h0000, 16'h0000, 10, 0, 0, 1, 0, 1));
        vecs.push_back(mkVec("abortSignal",   16'h03FE, 16'h03FF, 16'h0000, 16'h0100, 10, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("abortSigEarly", 16'h03FE, 16'h03FF, 16'h0000, 16'h0080, 10, 0, 0, 1, 0, 1));
        vecs.push_back(mkVec("abortNoFrame",  16'h03FE, 16'h0000, 16'h0000, 16'h0000, 10, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("abortSigAlone", 16'h03FF, 16'h03FF, 16'h0000, 16'h0010, 10, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("idleRun",       16'h00FF, 16'h0000, 16'h0000, 16'h0000, 11, 0, 0, 0, 3, 1));
        vecs.push_back(mkVec("idleZeroEarly", 16'h07EF, 16'h0000, 16'h0000, 16'h0000, 11, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("idleBound7",    16'h017F, 16'h0000, 16'h0000, 16'h0000,  9, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("idleBound8",    16'h00FF, 16'h0000, 16'h0000, 16'h0000,  9, 0, 0, 0, 1, 1));

        foreach (vecs[k]) begin
            doReset();
            applyStimulus(vecs[k].line, vecs[k].vf, vecs[k].fd, vecs[k].ab, 16'h0000, vecs[k].n);
            repeat (3) tick();
            checkCounts(vecs[k].name, vecs[k].expMiss, vecs[k].expSpur, vecs[k].expAbort, vecs[k].expIdle);
            checkOutput({vecs[k].name, ".ErrIrq0"}, 32'(ErrIrq[0]), 32'(vecs[k].expIrq));
            checkOutput({vecs[k].name, ".ErrAny"}, 32'(ErrAny), 32'(vecs[k].expIrq));
            checkOutput({vecs[k].name, ".ErrIrqOther"}, 32'(ErrIrq[3:1]), 32'd0);
        end

        // ErrIrq rises the cycle after the missed expectation, ErrAny one later
        doReset();
        applyStimulus(16'h017E, 16'h01FF, 16'h0000, 16'h0000, 16'h0000, 9);
        checkOutput("irqTiming.beforeMiss", 32'(ErrIrq[0]), 32'd0);
        applyStimulus(16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1);
        checkOutput("irqTiming.ErrIrq0", 32'(ErrIrq[0]), 32'd1);
        checkOutput("irqTiming.ErrAnyLag", 32'(ErrAny), 32'd0);
        tick();
        checkOutput("irqTiming.ErrAny", 32'(ErrAny), 32'd1);

        // Five misses saturate the 2-bit counter at 3; 8-bit counter reads 5
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(16'h037E, 16'h03FF, 16'h0000, 16'h0000, 16'h0000, 10);
        end
        RdCh  = 2'd0;
        RdSel = 2'(ERR_MISS_FLAG);
        tick();
        checkOutput("sat.wide", 32'(RdData), 32'd5);
        checkOutput("sat.narrow", 32'(RdDataS), 32'd3);
        RdCh = 2'd3;
        tick();
        checkOutput("rdOutOfRange.narrow", 32'(RdDataS), 32'd0);
        checkOutput("rdCh3.wide", 32'(RdData), 32'd0);
        // Clear lands in the same cycle as the sixth miss
        applyStimulus(16'h037E, 16'h03FF, 16'h0000, 16'h0000, 16'h0200, 10);
        RdCh = 2'd0;
        tick();
        checkOutput("clrDuringMiss.wide", 32'(RdData), 32'd1);
        checkOutput("clrDuringMiss.narrow", 32'(RdDataS), 32'd1);
        checkOutput("clrDuringMiss.ErrIrq0", 32'(ErrIrq[0]), 32'd1);
        ClrCnt[0] = 1'b1;
        tick();
        ClrCnt[0] = 1'b0;
        tick();
        checkOutput("clrQuiet.cnt", 32'(RdData), 32'd0);
        checkOutput("clrQuiet.ErrIrq0", 32'(ErrIrq[0]), 32'd0);

        // Reset asserted mid-flag after an error was logged
        doReset();
        applyStimulus(16'h037E, 16'h03FF, 16'h0000, 16'h0000, 16'h0000, 10);
        applyStimulus(16'h000E, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 4);
        #2;
        Rst = 1'b0;
        #1;
        checkOutput("midReset.ErrIrq", 32'(ErrIrq), 32'd0);
        checkOutput("midReset.ErrAny", 32'(ErrAny), 32'd0);
        tick();
        Rst = 1'b1;
        applyStimulus(16'h0037, 16'h003F, 16'h0000, 16'h0000, 16'h0000, 6);
        repeat (3) tick();
        checkCounts("midReset", 0, 0, 0, 0);
        checkOutput("midReset.ErrIrq0", 32'(ErrIrq[0]), 32'd0);

        // Disabled monitor ignores a missed flag; after enable, FlagDetect is
        // only judged once the checker has re-armed
        doReset();
        En = 1'b0;
        applyStimulus(16'h037E, 16'h03FF, 16'h0000, 16'h0000, 16'h0000, 10);
        En = 1'b1;
        applyStimulus(16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1);
        repeat (2) tick();
        checkCounts("enable", 0, 0, 0, 0);
        applyStimulus(16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1);
        repeat (2) tick();
        checkCounts("armed", 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
